// File: rtl/nora_mst_arbiter.sv
// nora_mst_arbiter: round-robin two-port NORA master arbiter with lock; optional busy timeout via NORA_MST_ARB_TIMEOUT_EN
module nora_mst_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk6x,
    input  logic        reset,
    input  logic [23:0] m0_addr_i,
    input  logic [7:0]  m0_data_i,
    input  logic        m0_rwn_i,
    input  logic        m0_req_SRAM_i,
    input  logic        m0_req_OTHER_i,
    input  logic        m0_lock_i,
    output logic [7:0]  m0_datard_o,
    output logic        m0_ack_o,
    input  logic [23:0] m1_addr_i,
    input  logic [7:0]  m1_data_i,
    input  logic        m1_rwn_i,
    input  logic        m1_req_SRAM_i,
    input  logic        m1_req_OTHER_i,
    input  logic        m1_lock_i,
    output logic [7:0]  m1_datard_o,
    output logic        m1_ack_o,
    output logic [23:0] nora_mst_addr_o,
    output logic [7:0]  nora_mst_data_o,
    output logic        nora_mst_rwn_o,
    output logic        nora_mst_req_SRAM_o,
    output logic        nora_mst_req_OTHER_o,
    input  logic [7:0]  nora_mst_datard_i,
    input  logic        nora_mst_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0] state;
    logic       last_grant, lock_valid, lock_owner;
    logic       req0, req1, lock_hold, win, win_ok, owner, owner_lock, tmo_hit, done;
    logic [7:0] rd_val;

    always_comb begin
        req0       = m0_req_SRAM_i | m0_req_OTHER_i;
        req1       = m1_req_SRAM_i | m1_req_OTHER_i;
        lock_hold  = lock_valid & (lock_owner ? m1_lock_i : m0_lock_i);
        win        = lock_hold ? lock_owner : (req0 & req1) ? ~last_grant : req1;
        win_ok     = lock_hold ? (lock_owner ? req1 : req0) : (req0 | req1);
        owner      = grant_o[1];
        owner_lock = owner ? m1_lock_i : m0_lock_i;
        done       = (state == BUSY) & (nora_mst_ack_i | tmo_hit);
        rd_val     = nora_mst_ack_i ? nora_mst_datard_i : 8'hFF;
    end

`ifdef NORA_MST_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    assign tmo_hit = (state == BUSY) & (tmo_cnt == 8'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk6x) begin
        if (reset) begin
            tmo_cnt   <= 8'd0;
            timeout_o <= 1'b0;
        end else begin
            tmo_cnt <= (state == BUSY) ? tmo_cnt + 8'd1 : 8'd0;
            if (tmo_hit && !nora_mst_ack_i)
                timeout_o <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk6x) begin
        if (reset) begin
            state                <= IDLE;
            last_grant           <= 1'b1;
            lock_valid           <= 1'b0;
            lock_owner           <= 1'b0;
            grant_o              <= 2'b00;
            m0_datard_o          <= 8'h00;
            m1_datard_o          <= 8'h00;
            m0_ack_o             <= 1'b0;
            m1_ack_o             <= 1'b0;
            nora_mst_addr_o      <= 24'h0;
            nora_mst_data_o      <= 8'h00;
            nora_mst_rwn_o       <= 1'b0;
            nora_mst_req_SRAM_o  <= 1'b0;
            nora_mst_req_OTHER_o <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            if (state == IDLE) begin
                if (lock_valid && !lock_hold)
                    lock_valid <= 1'b0;
                if (win_ok) begin
                    grant_o              <= win ? 2'b10 : 2'b01;
                    nora_mst_addr_o      <= win ? m1_addr_i : m0_addr_i;
                    nora_mst_data_o      <= win ? m1_data_i : m0_data_i;
                    nora_mst_rwn_o       <= win ? m1_rwn_i : m0_rwn_i;
                    nora_mst_req_SRAM_o  <= win ? m1_req_SRAM_i : m0_req_SRAM_i;
                    nora_mst_req_OTHER_o <= win ? m1_req_OTHER_i : m0_req_OTHER_i;
                    state                <= BUSY;
                end
            end else if (done) begin
                nora_mst_req_SRAM_o  <= 1'b0;
                nora_mst_req_OTHER_o <= 1'b0;
                grant_o              <= 2'b00;
                lock_valid           <= nora_mst_ack_i & owner_lock;
                lock_owner           <= owner;
                if (nora_mst_ack_i)
                    last_grant <= owner;
                if (owner) begin
                    m1_datard_o <= rd_val;
                    m1_ack_o    <= 1'b1;
                end else begin
                    m0_datard_o <= rd_val;
                    m0_ack_o    <= 1'b1;
                end
                state <= GAP;
            end else if (state == GAP) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_nora_mst_arbiter.sv
// tb_nora_mst_arbiter: directed self-checking bench for nora_mst_arbiter
module tb_nora_mst_arbiter;
    logic        clk6x = 1'b0;
    logic        reset;
    logic [23:0] m0_addr_i, m1_addr_i, nora_mst_addr_o;
    logic [7:0]  m0_data_i, m1_data_i, m0_datard_o, m1_datard_o, nora_mst_data_o, nora_mst_datard_i;
    logic        m0_rwn_i, m0_req_SRAM_i, m0_req_OTHER_i, m0_lock_i, m0_ack_o;
    logic        m1_rwn_i, m1_req_SRAM_i, m1_req_OTHER_i, m1_lock_i, m1_ack_o;
    logic        nora_mst_rwn_o, nora_mst_req_SRAM_o, nora_mst_req_OTHER_o, nora_mst_ack_i, timeout_o;
    logic [1:0]  grant_o;
    int          total = 0;
    int          bad = 0;

    always #5 clk6x = ~clk6x;

    nora_mst_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk6x(clk6x), .reset(reset),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_rwn_i(m0_rwn_i),
        .m0_req_SRAM_i(m0_req_SRAM_i), .m0_req_OTHER_i(m0_req_OTHER_i), .m0_lock_i(m0_lock_i),
        .m0_datard_o(m0_datard_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_rwn_i(m1_rwn_i),
        .m1_req_SRAM_i(m1_req_SRAM_i), .m1_req_OTHER_i(m1_req_OTHER_i), .m1_lock_i(m1_lock_i),
        .m1_datard_o(m1_datard_o), .m1_ack_o(m1_ack_o),
        .nora_mst_addr_o(nora_mst_addr_o), .nora_mst_data_o(nora_mst_data_o), .nora_mst_rwn_o(nora_mst_rwn_o),
        .nora_mst_req_SRAM_o(nora_mst_req_SRAM_o), .nora_mst_req_OTHER_o(nora_mst_req_OTHER_o),
        .nora_mst_datard_i(nora_mst_datard_i), .nora_mst_ack_i(nora_mst_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk6x);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        {m0_addr_i, m0_data_i, m0_rwn_i, m0_req_SRAM_i, m0_req_OTHER_i, m0_lock_i} = '0;
        {m1_addr_i, m1_data_i, m1_rwn_i, m1_req_SRAM_i, m1_req_OTHER_i, m1_lock_i} = '0;
        nora_mst_datard_i = 8'h00;
        nora_mst_ack_i = 1'b0;
        step(2);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_acks", {m0_ack_o, m1_ack_o}, 2'b00);
        chk("rst_reqs", {nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 2'b00);
        chk("rst_addr", nora_mst_addr_o, 24'h0);
        chk("rst_timeout", timeout_o, 1'b0);
        reset = 1'b0;

        // single read
        m0_addr_i = 24'h012345; m0_rwn_i = 1'b1; m0_req_SRAM_i = 1'b1;
        step(1);
        chk("rd_grant", grant_o, 2'b01);
        chk("rd_addr", nora_mst_addr_o, 24'h012345);
        chk("rd_req", {nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 2'b10);
        chk("rd_rwn", nora_mst_rwn_o, 1'b1);
        step(4);
        chk("rd_noack_yet", m0_ack_o, 1'b0);
        nora_mst_ack_i = 1'b1; nora_mst_datard_i = 8'hA5;
        step(1);
        chk("rd_ack0", m0_ack_o, 1'b1);
        chk("rd_ack1", m1_ack_o, 1'b0);
        chk("rd_data", m0_datard_o, 8'hA5);
        chk("rd_req_off", nora_mst_req_SRAM_o, 1'b0);
        chk("rd_gap_grant", grant_o, 2'b00);
        nora_mst_ack_i = 1'b0; m0_req_SRAM_i = 1'b0;
        step(1);
        chk("rd_ack_pulse", m0_ack_o, 1'b0);
        chk("rd_data_hold", m0_datard_o, 8'hA5);

        // tie after reset
        reset = 1'b1; step(1); reset = 1'b0;
        m0_addr_i = 24'h000100; m0_req_SRAM_i = 1'b1;
        m1_addr_i = 24'h000200; m1_req_OTHER_i = 1'b1; m1_rwn_i = 1'b1;
        step(1);
        chk("tie_g0", grant_o, 2'b01);
        chk("tie_req0", {nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 2'b10);
        step(1);
        nora_mst_ack_i = 1'b1; nora_mst_datard_i = 8'h5A;
        step(1);
        nora_mst_ack_i = 1'b0;
        chk("tie_gap1", grant_o, 2'b00);
        chk("tie_ack0", {m0_ack_o, m1_ack_o}, 2'b10);
        step(1);
        chk("tie_gap1b", grant_o, 2'b00);
        step(1);
        chk("tie_g1", grant_o, 2'b10);
        chk("tie_addr1", nora_mst_addr_o, 24'h000200);
        chk("tie_req1", {nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 2'b01);
        nora_mst_ack_i = 1'b1; nora_mst_datard_i = 8'h3C;
        step(1);
        nora_mst_ack_i = 1'b0; m1_req_OTHER_i = 1'b0;
        chk("tie_gap2", grant_o, 2'b00);
        chk("tie_ack1", {m0_ack_o, m1_ack_o}, 2'b01);
        chk("tie_data1", m1_datard_o, 8'h3C);
        chk("tie_data0_kept", m0_datard_o, 8'h5A);
        step(2);
        chk("tie_g0_again", grant_o, 2'b01);

        // lock: port 1 writes with lock 1,1,0 while port 0 keeps requesting
        nora_mst_ack_i = 1'b1;
        step(1);
        nora_mst_ack_i = 1'b0;
        m1_req_SRAM_i = 1'b1; m1_rwn_i = 1'b0; m1_lock_i = 1'b1; m1_data_i = 8'h31;
        step(2);
        chk("lk_g1", grant_o, 2'b10);
        chk("lk_d1", nora_mst_data_o, 8'h31);
        chk("lk_rwn", nora_mst_rwn_o, 1'b0);
        nora_mst_ack_i = 1'b1;
        step(1);
        nora_mst_ack_i = 1'b0; m1_data_i = 8'h32;
        step(2);
        chk("lk_g2", grant_o, 2'b10);
        chk("lk_d2", nora_mst_data_o, 8'h32);
        nora_mst_ack_i = 1'b1;
        step(1);
        nora_mst_ack_i = 1'b0; m1_data_i = 8'h33;
        step(2);
        chk("lk_g3", grant_o, 2'b10);
        chk("lk_d3", nora_mst_data_o, 8'h33);
        m1_lock_i = 1'b0;
        nora_mst_ack_i = 1'b1;
        step(1);
        nora_mst_ack_i = 1'b0; m1_req_SRAM_i = 1'b0;
        chk("lk_ack3", m1_ack_o, 1'b1);
        step(2);
        chk("lk_then_p0", grant_o, 2'b01);
        nora_mst_ack_i = 1'b1;
        step(1);
        nora_mst_ack_i = 1'b0; m0_req_SRAM_i = 1'b0;
        step(2);
        chk("idle_nogrant", grant_o, 2'b00);

        // input change during BUSY, stray ack in IDLE
        m0_data_i = 8'h11; m0_rwn_i = 1'b0; m0_req_OTHER_i = 1'b1;
        step(1);
        chk("frz_grant", grant_o, 2'b01);
        chk("frz_d", nora_mst_data_o, 8'h11);
        chk("frz_req", {nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 2'b01);
        m0_data_i = 8'h22;
        step(2);
        chk("frz_hold", nora_mst_data_o, 8'h11);
        nora_mst_ack_i = 1'b1; nora_mst_datard_i = 8'h77;
        step(1);
        nora_mst_ack_i = 1'b0; m0_req_OTHER_i = 1'b0;
        chk("frz_ack", m0_ack_o, 1'b1);
        step(2);
        nora_mst_ack_i = 1'b1; nora_mst_datard_i = 8'hEE;
        step(1);
        nora_mst_ack_i = 1'b0;
        chk("stray_acks", {m0_ack_o, m1_ack_o}, 2'b00);
        chk("stray_data", m0_datard_o, 8'h77);
        chk("stray_grant", grant_o, 2'b00);

        // reset mid-BUSY; last winner was port 0 so port 1 takes this tie
        m0_req_SRAM_i = 1'b1; m1_req_SRAM_i = 1'b1;
        step(1);
        chk("mr_grant", grant_o, 2'b10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mr_grant0", grant_o, 2'b00);
        chk("mr_reqs", {nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 2'b00);
        chk("mr_addr", nora_mst_addr_o, 24'h0);
        chk("mr_datard", {m0_datard_o, m1_datard_o}, 16'h0000);
        step(1);
        chk("mr_tie_p0", grant_o, 2'b01);
        nora_mst_ack_i = 1'b1;
        step(1);
        nora_mst_ack_i = 1'b0; m0_req_SRAM_i = 1'b0; m1_req_SRAM_i = 1'b0;
        chk("mr_ack", {m0_ack_o, m1_ack_o}, 2'b10);
        step(2);

`ifdef NORA_MST_ARB_TIMEOUT_EN
        m0_req_SRAM_i = 1'b1; m0_rwn_i = 1'b1;
        step(1);
        chk("to_grant", grant_o, 2'b01);
        step(15);
        chk("to_early", m0_ack_o, 1'b0);
        chk("to_flag_early", timeout_o, 1'b0);
        step(1);
        chk("to_ack", m0_ack_o, 1'b1);
        chk("to_data", m0_datard_o, 8'hFF);
        chk("to_flag", timeout_o, 1'b1);
        chk("to_req_off", nora_mst_req_SRAM_o, 1'b0);
        m0_req_SRAM_i = 1'b0;
        step(3);
        chk("to_sticky", timeout_o, 1'b1);
`else
        chk("no_timeout", timeout_o, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
